// File: rtl/break_select_engine.sv
// break_select_engine: WalkSAT break-value counter and greedy/noise flip selector; ZERO_BREAK_FREEBIE_EN makes zero-break greedy picks override noise
module break_select_engine #(
  parameter int NSAT = 3,
  parameter int NSAT_BITS = 2,
  parameter int MC = 20,
  parameter int MCB = 5,
  parameter logic [31:0] P = 32'h6E147AE0
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [NSAT-1:0]      candidate_valid_i,
  input  logic                 row_valid_i,
  output logic                 row_ready_o,
  input  logic [MC-1:0]        clause_broken_i,
  input  logic [MC-1:0]        mask_bits_i,
  input  logic [31:0]          random_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NSAT_BITS-1:0] select_o,
  output logic [MCB-1:0]       break_value_o,
  output logic [MC-1:0]        clause_broken_bits_o
);
  typedef enum logic [1:0] {IDLE, COLLECT, SELECT} state_t;
  state_t state, state_n;
  logic [NSAT_BITS-1:0] cnt, ridx, lidx, gidx, pick;
  logic [NSAT-1:0] vld;
  logic [MC-1:0] bits [NSAT];
  logic [MCB-1:0] bv [NSAT];
  logic [MCB-1:0] gbv;
  logic beat, last, gfound, noise, use_rnd;
  function automatic logic [MCB-1:0] sat_pop(input logic [MC-1:0] b);
    int c;
    c = 0;
    for (int i = 0; i < MC; i++) c += int'(b[i]);
    return c >= (1 << MCB) - 1 ? '1 : MCB'(c);
  endfunction
  assign row_ready_o = state == COLLECT;
  assign busy_o = state != IDLE;
  assign beat = row_valid_i && row_ready_o;
  assign last = cnt == NSAT_BITS'(NSAT - 1);
  always_comb begin
    state_n = state == IDLE ? (start_i ? COLLECT : IDLE) :
              state == COLLECT ? (beat && last ? SELECT : COLLECT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    ridx = NSAT_BITS'((32'(random_i[15:0]) * 32'(NSAT)) >> 16);
    lidx = '0;
    for (int k = NSAT - 1; k >= 0; k--) if (vld[k]) lidx = NSAT_BITS'(k);
    gfound = 1'b0;
    gidx = '0;
    gbv = '1;
    for (int k = 0; k < NSAT; k++)
      if (vld[k] && (!gfound || bv[k] < gbv)) begin
        gfound = 1'b1;
        gidx = NSAT_BITS'(k);
        gbv = bv[k];
      end
    noise = random_i[31:16] < P[31:16];
`ifdef ZERO_BREAK_FREEBIE_EN
    use_rnd = noise && !(gfound && gbv == '0);
`else
    use_rnd = noise;
`endif
    pick = use_rnd ? (vld[ridx] ? ridx : lidx) : gidx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      vld <= '0;
      done_o <= 1'b0;
      select_o <= '0;
      break_value_o <= '0;
      clause_broken_bits_o <= '0;
      for (int k = 0; k < NSAT; k++) begin
        bits[k] <= '0;
        bv[k] <= '0;
      end
    end else begin
      done_o <= state == SELECT;
      if (state == IDLE && start_i) begin
        vld <= candidate_valid_i;
        cnt <= '0;
      end
      if (beat) begin
        bits[cnt] <= clause_broken_i & mask_bits_i;
        bv[cnt] <= sat_pop(clause_broken_i & mask_bits_i);
        cnt <= cnt + NSAT_BITS'(1);
      end
      if (state == SELECT) begin
        select_o <= pick;
        break_value_o <= gfound ? bv[pick] : '1;
        clause_broken_bits_o <= gfound ? bits[pick] : '0;
      end
    end
  end
endmodule

// File: tb/tb_break_select_engine.sv
// tb_break_select_engine: directed self-checking bench for break_select_engine
module tb_break_select_engine;
  logic clk = 0, reset = 1, start_i = 0, row_valid_i = 0;
  logic [2:0] candidate_valid_i = 0;
  logic [19:0] clause_broken_i = 0, mask_bits_i = 0;
  logic [31:0] random_i = 0;
  logic row_ready_o, busy_o, done_o;
  logic [1:0] select_o;
  logic [4:0] break_value_o;
  logic [19:0] clause_broken_bits_o;
  int checks = 0, errors = 0;
  int lat;
  always #5 clk = ~clk;
  break_select_engine dut (
    .clk(clk), .reset(reset), .start_i(start_i), .candidate_valid_i(candidate_valid_i),
    .row_valid_i(row_valid_i), .row_ready_o(row_ready_o), .clause_broken_i(clause_broken_i),
    .mask_bits_i(mask_bits_i), .random_i(random_i), .busy_o(busy_o), .done_o(done_o),
    .select_o(select_o), .break_value_o(break_value_o), .clause_broken_bits_o(clause_broken_bits_o)
  );
  function automatic logic [19:0] ones(input int n);
    return 20'((64'd1 << n) - 1);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [19:0] b, input logic [19:0] m, input int gaps);
    row_valid_i = 0;
    for (int g = 0; g < gaps; g++) tick();
    row_valid_i = 1;
    clause_broken_i = b;
    mask_bits_i = m;
    tick();
    row_valid_i = 0;
  endtask
  task automatic run_sel(input logic [2:0] v, input logic [19:0] b0, b1, b2, m0, m1, m2,
                         input logic [31:0] rnd, input int gaps, output int edges);
    start_i = 1;
    candidate_valid_i = v;
    random_i = rnd;
    tick();
    start_i = 0;
    beat(b0, m0, gaps);
    beat(b1, m1, gaps);
    beat(b2, m2, gaps);
    edges = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (done_o) begin
        edges = c;
        break;
      end
    end
  endtask
  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    checks++;
    if ({busy_o, row_ready_o, done_o, select_o, break_value_o, clause_broken_bits_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ready=%b done=%b sel=%0d bv=%0d bits=%h required all 0",
               busy_o, row_ready_o, done_o, select_o, break_value_o, clause_broken_bits_o);
    end
  endtask
  task automatic test_greedy();
    run_sel(3'b111, ones(4), ones(2), ones(3), '1, '1, '1, 32'hFFFF0000, 0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL greedy_latency: done after %0d edges past last beat, required 1", lat); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL greedy_busy: got %b required 0", busy_o); end
    checks++;
    if ({select_o, break_value_o, clause_broken_bits_o} !== {2'd1, 5'd2, ones(2)}) begin
      errors++;
      $display("FAIL greedy_result: got sel=%0d bv=%0d bits=%h required sel=1 bv=2 bits=%h",
               select_o, break_value_o, clause_broken_bits_o, ones(2));
    end
    tick();
    checks++;
    if ({done_o, select_o, break_value_o} !== {1'b0, 2'd1, 5'd2}) begin
      errors++;
      $display("FAIL greedy_hold: got done=%b sel=%0d bv=%0d required done=0 sel=1 bv=2", done_o, select_o, break_value_o);
    end
  endtask
  task automatic test_tie_mask();
    run_sel(3'b111, 20'hFFFFF, 20'h0, 20'h0, 20'h0, '1, '1, 32'hFFFF0000, 0, lat);
    checks++;
    if ({lat[3:0], select_o, break_value_o, clause_broken_bits_o} !== {4'd1, 2'd0, 5'd0, 20'h0}) begin
      errors++;
      $display("FAIL tie_mask: got lat=%0d sel=%0d bv=%0d bits=%h required lat=1 sel=0 bv=0 bits=0",
               lat, select_o, break_value_o, clause_broken_bits_o);
    end
  endtask
  task automatic test_noise();
    run_sel(3'b111, ones(1), ones(4), ones(5), '1, '1, '1, 32'h0000C000, 0, lat);
    checks++;
    if ({select_o, break_value_o, clause_broken_bits_o} !== {2'd2, 5'd5, ones(5)}) begin
      errors++;
      $display("FAIL noise_ridx: got sel=%0d bv=%0d bits=%h required sel=2 bv=5", select_o, break_value_o, clause_broken_bits_o);
    end
    run_sel(3'b011, ones(1), ones(4), ones(5), '1, '1, '1, 32'h0000C000, 0, lat);
    checks++;
    if ({select_o, break_value_o, clause_broken_bits_o} !== {2'd0, 5'd1, ones(1)}) begin
      errors++;
      $display("FAIL noise_invalid_ridx: got sel=%0d bv=%0d bits=%h required sel=0 bv=1", select_o, break_value_o, clause_broken_bits_o);
    end
  endtask
  task automatic test_freebie();
    logic [1:0] exp_sel;
`ifdef ZERO_BREAK_FREEBIE_EN
    exp_sel = 2'd0;
`else
    exp_sel = 2'd2;
`endif
    run_sel(3'b111, ones(0), ones(5), ones(5), '1, '1, '1, 32'h0000C000, 0, lat);
    checks++;
    if (select_o !== exp_sel) begin
      errors++;
      $display("FAIL freebie: got sel=%0d required %0d", select_o, exp_sel);
    end
  endtask
  task automatic test_no_valid();
    run_sel(3'b000, ones(3), ones(1), ones(2), '1, '1, '1, 32'hFFFF0000, 0, lat);
    checks++;
    if ({lat[3:0], select_o, break_value_o, clause_broken_bits_o} !== {4'd1, 2'd0, 5'h1F, 20'h0}) begin
      errors++;
      $display("FAIL no_valid: got lat=%0d sel=%0d bv=%0d bits=%h required lat=1 sel=0 bv=31 bits=0",
               lat, select_o, break_value_o, clause_broken_bits_o);
    end
  endtask
  task automatic test_handshake();
    row_valid_i = 1;
    clause_broken_i = '1;
    mask_bits_i = '1;
    tick();
    checks++;
    if ({row_ready_o, busy_o} !== 2'b00) begin errors++; $display("FAIL idle_ready: got ready=%b busy=%b required 0 0", row_ready_o, busy_o); end
    row_valid_i = 0;
    start_i = 1;
    candidate_valid_i = 3'b101;
    random_i = 32'hFFFF0000;
    tick();
    start_i = 0;
    checks++;
    if ({row_ready_o, busy_o} !== 2'b11) begin errors++; $display("FAIL collect_ready: got ready=%b busy=%b required 1 1", row_ready_o, busy_o); end
    beat(ones(4), '1, 2);
    beat(ones(0), '1, 3);
    beat(ones(2), '1, 1);
    checks++;
    if ({row_ready_o, busy_o, done_o} !== 3'b010) begin
      errors++;
      $display("FAIL select_state: got ready=%b busy=%b done=%b required 0 1 0", row_ready_o, busy_o, done_o);
    end
    start_i = 1;
    row_valid_i = 1;
    clause_broken_i = '1;
    tick();
    start_i = 0;
    row_valid_i = 0;
    checks++;
    if ({done_o, busy_o, select_o, break_value_o} !== {1'b1, 1'b0, 2'd2, 5'd2}) begin
      errors++;
      $display("FAIL handshake_result: got done=%b busy=%b sel=%0d bv=%0d required 1 0 sel=2 bv=2",
               done_o, busy_o, select_o, break_value_o);
    end
    tick();
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL select_start_ignored: got busy=%b done=%b required 0 0", busy_o, done_o); end
  endtask
  task automatic test_back_to_back();
    run_sel(3'b111, ones(6), ones(7), ones(3), '1, '1, '1, 32'hFFFF0000, 0, lat);
    run_sel(3'b111, ones(9), ones(8), ones(10), '1, '1, '1, 32'hFFFF0000, 0, lat);
    checks++;
    if ({lat[3:0], select_o, break_value_o} !== {4'd1, 2'd1, 5'd8}) begin
      errors++;
      $display("FAIL back_to_back: got lat=%0d sel=%0d bv=%0d required lat=1 sel=1 bv=8", lat, select_o, break_value_o);
    end
  endtask
  task automatic test_reset_abort();
    int seen;
    start_i = 1;
    candidate_valid_i = 3'b111;
    tick();
    start_i = 0;
    beat(ones(1), '1, 0);
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({busy_o, row_ready_o, done_o, select_o, break_value_o, clause_broken_bits_o} !== '0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b ready=%b done=%b sel=%0d bv=%0d bits=%h required all 0",
               busy_o, row_ready_o, done_o, select_o, break_value_o, clause_broken_bits_o);
    end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen += int'(done_o);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses required 0", seen); end
    run_sel(3'b111, ones(4), ones(2), ones(3), '1, '1, '1, 32'hFFFF0000, 0, lat);
    checks++;
    if ({lat[3:0], select_o, break_value_o, clause_broken_bits_o} !== {4'd1, 2'd1, 5'd2, ones(2)}) begin
      errors++;
      $display("FAIL abort_fresh_run: got lat=%0d sel=%0d bv=%0d bits=%h required lat=1 sel=1 bv=2",
               lat, select_o, break_value_o, clause_broken_bits_o);
    end
  endtask
  initial begin
    test_reset();
    test_greedy();
    test_tie_mask();
    test_noise();
    test_freebie();
    test_no_valid();
    test_handshake();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
